sensor_acq_responder: RTL and testbench
=======================================

Name: sensor_acq_responder

Overview:
- Sensor-side end of the trigger/done timing handshake. One instance per sensor channel (eddy 0-3, encoder, ADC).
- Consumes the timing manager's trigger pulse and the channel enable bit.
- Launches one acquisition on the sensor front end, waits for data or a timeout, and latches the sample.
- Drives the level done signal that the timing manager ANDs into all_done and edge-detects to capture acquisition time.

Parameters:
DATA_W, 16, width of sensor sample
CNT_W, 16, width of acquisition/timeout counter and statistics counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
trigger  input  1  one-cycle acquisition request from timing manager
en  input  1  channel enable bit from timing manager
timeout_cycles  input  CNT_W  max WAIT cycles; 0 = timeout disabled
data_valid  input  1  front end sample-ready strobe
data_in  input  DATA_W  front end sample
start  output  1  one-cycle conversion start to front end
busy  output  1  high in START or WAIT
done  output  1  level; high from completion until next accepted trigger
data_out  output  DATA_W  last latched sample
timeout_err  output  1  last acquisition ended by timeout
acq_cycles  output  CNT_W  cycles from start to data_valid (inclusive) of last good acquisition
missed_trig_count  output  CNT_W  triggers received while busy, saturating

Behaviour:
- Reset is synchronous, active-high. Interface fixed: one clock, clk; reset rst, synchronous, active-high.
- Reset values: state IDLE, start=0, busy=0, done=0, data_out=0, timeout_err=0, acq_cycles=0, missed_trig_count=0, internal counter=0.
- Reset asserted mid-acquisition: same values next cycle; no further start pulse.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE / DONE, trigger && en:
  - next state START.
  - done<=0, timeout_err<=0.
  - data_out and acq_cycles hold.
- IDLE / DONE, trigger && !en: ignored.
- START:
  - start=1 for exactly this cycle; busy=1.
  - counter<=0; next state WAIT.
- WAIT: busy=1; counter increments by 1 per cycle, saturating at all-ones. Exits are checked in this priority order:
  1. data_valid: data_out<=data_in, acq_cycles<=counter+1 (saturating), done<=1, next DONE.
  2. timeout_cycles!=0 && counter+1==timeout_cycles: timeout_err<=1, done<=1, data_out holds, acq_cycles holds, next DONE.
  - data_valid and timeout in the same cycle: data wins, timeout_err=0.
- Timeout purpose: guarantees done rises so all_done never stalls on a dead sensor.
- Latency: trigger sampled at cycle N -> start high at N+1, done low from N+1. First data_valid at N+2+k -> done high at N+3+k, acq_cycles=k+1.
- trigger while in START or WAIT:
  - missed_trig_count increments, saturating at all-ones.
  - Acquisition continues unaffected; the trigger is not queued.
- en deasserted in START or WAIT:
  - abort to IDLE next cycle; done=0, busy=0.
  - data_out, acq_cycles, timeout_err hold.
- en deasserted in DONE: state DONE retained, done stays high.
- data_valid outside WAIT: ignored.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: FSM state enum (IDLE, START, WAIT, DONE), default DATA_W/CNT_W constants, saturating-increment function.
- Natural sub-module: sat_counter (CNT_W, clear/increment/saturate). Used for both the WAIT counter and missed_trig_count.

Test Plan:
- Reset then en=1, trigger at N, data_valid at N+5 with data_in=0x1234 -> start high only at N+1; done rises N+6; data_out=0x1234; acq_cycles=4; timeout_err=0.
- timeout_cycles=10, no data_valid -> done and timeout_err rise 10 cycles after START; data_out unchanged; busy low from the cycle done rises.
- timeout_cycles=3, data_valid on the same cycle the timeout would fire -> timeout_err=0; data latched; acq_cycles=3.
- Three triggers during WAIT, then data -> missed_trig_count=3; single start pulse; one done rise. Preload to 0xFFFF then trigger again during WAIT -> remains 0xFFFF.
- en=0 with trigger -> no start, done stays 0. Deassert en mid-WAIT -> IDLE next cycle; busy=0; later data_valid ignored.
- rst pulsed one cycle during WAIT with done previously high -> all outputs at reset values next cycle; subsequent trigger runs a normal acquisition.

Source files
------------

// File: rtl/sensor_acq_responder_pkg.sv
// Shared types and helpers for the sensor acquisition responder.
// Holds the FSM state encoding, default widths and the saturating increment.
package sensor_acq_responder_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } acq_state_e;

   // Widths up to 32 bits are handled by zero-extending into the 32-bit argument.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
      logic [31:0] result;
      if (value >= max_val) begin
         result = max_val;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sensor_acq_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sensor_acq_responder_sat_counter
   import sensor_acq_responder_pkg::*;
#(
   parameter int W = DEF_CNT_W
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [31:0] MAX_C = 32'({W{1'b1}});

   logic [W-1:0] w_next;

   assign w_next = W'(sat_inc(32'(count), MAX_C));

   // Count register: reset, clear, saturating increment or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {W{1'b0}};
      end else if (clr) begin
         count <= {W{1'b0}};
      end else if (inc) begin
         count <= w_next;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/sensor_acq_responder.sv
// Sensor-side trigger/done responder: launches one acquisition per accepted
// trigger, waits for data or timeout, latches the sample and holds done high.
module sensor_acq_responder
   import sensor_acq_responder_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              trigger,
   input  logic              en,
   input  logic [CNT_W-1:0]  timeout_cycles,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              start,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data_out,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  acq_cycles,
   output logic [CNT_W-1:0]  missed_trig_count
);

   localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

   acq_state_e       r_state;
   logic [CNT_W-1:0] w_wait_cnt;
   logic [CNT_W-1:0] w_wait_cnt_inc;
   logic             w_in_acq;
   logic             w_wait_clr;
   logic             w_wait_inc;
   logic             w_miss_inc;
   logic             w_timeout_hit;

   assign w_in_acq       = (r_state == ST_START) || (r_state == ST_WAIT);
   assign w_wait_clr     = (r_state == ST_START);
   assign w_wait_inc     = (r_state == ST_WAIT);
   assign w_miss_inc     = trigger && w_in_acq;
   assign w_wait_cnt_inc = CNT_W'(sat_inc(32'(w_wait_cnt), CNT_MAX));
   assign w_timeout_hit  = (timeout_cycles != {CNT_W{1'b0}}) && (w_wait_cnt_inc == timeout_cycles);

   sensor_acq_responder_sat_counter #(.W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_wait_clr),
      .inc   (w_wait_inc),
      .count (w_wait_cnt)
   );

   sensor_acq_responder_sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (w_miss_inc),
      .count (missed_trig_count)
   );

   // Acquisition FSM with all handshake outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         start       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         data_out    <= {DATA_W{1'b0}};
         timeout_err <= 1'b0;
         acq_cycles  <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (trigger && en) begin
                  r_state     <= ST_START;
                  start       <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  timeout_err <= 1'b0;
               end else begin
                  start <= 1'b0;
               end
            end
            ST_START: begin
               start <= 1'b0;
               if (!en) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               start <= 1'b0;
               // Abort beats data, and data beats timeout.
               if (!en) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else if (data_valid) begin
                  r_state     <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  data_out    <= data_in;
                  acq_cycles  <= w_wait_cnt_inc;
                  timeout_err <= 1'b0;
               end else if (w_timeout_hit) begin
                  r_state     <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               start   <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_acq_responder.sv
// Directed self-checking bench for sensor_acq_responder.
module tb_sensor_acq_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trigger = 1'b0;
   logic        en = 1'b0;
   logic [15:0] timeout_cycles = 16'd0;
   logic        data_valid = 1'b0;
   logic [15:0] data_in = 16'd0;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] data_out;
   logic        timeout_err;
   logic [15:0] acq_cycles;
   logic [15:0] missed_trig_count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int n_done_rise = 0;
   logic done_prev = 1'b0;
   int base_start;
   int base_rise;

   sensor_acq_responder #(.DATA_W(16), .CNT_W(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .trigger           (trigger),
      .en                (en),
      .timeout_cycles    (timeout_cycles),
      .data_valid        (data_valid),
      .data_in           (data_in),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .data_out          (data_out),
      .timeout_err       (timeout_err),
      .acq_cycles        (acq_cycles),
      .missed_trig_count (missed_trig_count)
   );

   always #5 clk = ~clk;

   // Pulse monitors sampled on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      if (start) n_start = n_start + 1;
      if (done && !done_prev) n_done_rise = n_done_rise + 1;
      done_prev = done;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      tick(); tick();
      check("rst_start", 32'(start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_acq", 32'(acq_cycles), 32'd0);
      check("rst_miss", 32'(missed_trig_count), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      tick();

      // Basic acquisition: data_valid at N+5 -> acq_cycles = 4
      base_start = n_start;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t1_start_n1", 32'(start), 32'd1);
      check("t1_busy_n1", 32'(busy), 32'd1);
      tick();
      check("t1_start_n2", 32'(start), 32'd0);
      tick(); tick(); tick();
      check("t1_done_n5", 32'(done), 32'd0);
      data_valid = 1'b1;
      data_in    = 16'h1234;
      tick();
      data_valid = 1'b0;
      check("t1_done", 32'(done), 32'd1);
      check("t1_data", 32'(data_out), 32'h1234);
      check("t1_acq", 32'(acq_cycles), 32'd4);
      check("t1_terr", 32'(timeout_err), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_nstart", 32'(n_start - base_start), 32'd1);

      // Timeout after 10 WAIT cycles
      timeout_cycles = 16'd10;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t2_done_clr", 32'(done), 32'd0);
      repeat (10) tick();
      check("t2_done_early", 32'(done), 32'd0);
      check("t2_busy_early", 32'(busy), 32'd1);
      tick();
      check("t2_done", 32'(done), 32'd1);
      check("t2_terr", 32'(timeout_err), 32'd1);
      check("t2_busy", 32'(busy), 32'd0);
      check("t2_data", 32'(data_out), 32'h1234);
      check("t2_acq", 32'(acq_cycles), 32'd4);

      // Data and timeout coincide: data wins
      timeout_cycles = 16'd3;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t3_terr_clr", 32'(timeout_err), 32'd0);
      tick(); tick(); tick();
      check("t3_done_pre", 32'(done), 32'd0);
      data_valid = 1'b1;
      data_in    = 16'hABCD;
      tick();
      data_valid = 1'b0;
      check("t3_done", 32'(done), 32'd1);
      check("t3_terr", 32'(timeout_err), 32'd0);
      check("t3_data", 32'(data_out), 32'hABCD);
      check("t3_acq", 32'(acq_cycles), 32'd3);

      // en low while in DONE keeps done high
      en = 1'b0;
      tick(); tick();
      check("t3_done_en0", 32'(done), 32'd1);
      en = 1'b1;
      timeout_cycles = 16'd0;

      // Three triggers during WAIT
      base_start = n_start;
      base_rise  = n_done_rise;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         trigger = 1'b1;
         tick();
         trigger = 1'b0;
         tick();
      end
      data_valid = 1'b1;
      data_in    = 16'h5555;
      tick();
      data_valid = 1'b0;
      tick();
      check("t4_miss", 32'(missed_trig_count), 32'd3);
      check("t4_nstart", 32'(n_start - base_start), 32'd1);
      check("t4_nrise", 32'(n_done_rise - base_rise), 32'd1);
      check("t4_data", 32'(data_out), 32'h5555);

      // Saturation of missed-trigger and WAIT counters
      base_start = n_start;
      trigger = 1'b1;
      repeat (65540) tick();
      check("t4_miss_sat", 32'(missed_trig_count), 32'h0000FFFF);
      tick();
      check("t4_miss_hold", 32'(missed_trig_count), 32'h0000FFFF);
      trigger = 1'b0;
      data_valid = 1'b1;
      data_in    = 16'h0F0F;
      tick();
      data_valid = 1'b0;
      check("t4_acq_sat", 32'(acq_cycles), 32'h0000FFFF);
      check("t4_sat_done", 32'(done), 32'd1);
      check("t4_sat_nstart", 32'(n_start - base_start), 32'd1);

      // Abort mid-WAIT, then late data_valid is ignored
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick(); tick();
      en = 1'b0;
      tick();
      check("t5_abort_busy", 32'(busy), 32'd0);
      check("t5_abort_done", 32'(done), 32'd0);
      check("t5_abort_data", 32'(data_out), 32'h0F0F);
      check("t5_abort_acq", 32'(acq_cycles), 32'h0000FFFF);
      data_valid = 1'b1;
      data_in    = 16'hDEAD;
      tick();
      data_valid = 1'b0;
      check("t5_ign_data", 32'(data_out), 32'h0F0F);
      check("t5_ign_done", 32'(done), 32'd0);

      // Trigger with en low does nothing
      base_start = n_start;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t5_en0_start", 32'(start), 32'd0);
      tick();
      check("t5_en0_done", 32'(done), 32'd0);
      check("t5_en0_busy", 32'(busy), 32'd0);
      check("t5_en0_nstart", 32'(n_start - base_start), 32'd0);

      // Reset pulse mid-WAIT with done previously high
      en = 1'b1;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      data_valid = 1'b1;
      data_in    = 16'h7777;
      tick();
      data_valid = 1'b0;
      check("t6_pre_done", 32'(done), 32'd1);
      check("t6_pre_acq", 32'(acq_cycles), 32'd1);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_start", 32'(start), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      check("t6_rst_data", 32'(data_out), 32'd0);
      check("t6_rst_terr", 32'(timeout_err), 32'd0);
      check("t6_rst_acq", 32'(acq_cycles), 32'd0);
      check("t6_rst_miss", 32'(missed_trig_count), 32'd0);
      tick();
      check("t6_no_start", 32'(start), 32'd0);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("t6_start", 32'(start), 32'd1);
      tick(); tick();
      data_valid = 1'b1;
      data_in    = 16'h2468;
      tick();
      data_valid = 1'b0;
      check("t6_done", 32'(done), 32'd1);
      check("t6_data", 32'(data_out), 32'h2468);
      check("t6_acq", 32'(acq_cycles), 32'd2);
      check("t6_miss", 32'(missed_trig_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
